// File: rtl/uart_param_core.sv
// uart_param_core: parametrised UART with a programmable baud divider, selectable
// oversampling, 5..9 data bits, optional odd/even parity and 1 or 2 stop bits.
//
// Ports:
//   CLK, RESET           single clock, synchronous active-high reset
//   BAUD_VAL             tick period = BAUD_VAL+1 clocks
//   NUM_BITS             data bits per frame (clamped to 5..DATA_WIDTH)
//   PARITY_EN/ODD_N_EVEN parity enable and sense
//   STOP2                TX sends two stop bits
//   WR_EN/DATA_IN        push into the TX FIFO
//   RD_EN/DATA_OUT       pop / first-word fall-through head of the RX FIFO
//   RX/TX                serial pins (RX is asynchronous)
//   TX_FULL..RX_COUNT    FIFO status
//   TX_BUSY              TX frame in progress
//   CLR_ERR              clears the sticky error flags
//   PARITY_ERR, FRAMING_ERR, OVERFLOW, BREAK_DET  sticky error flags
module uart_param_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned BAUD_WIDTH = 16
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic [BAUD_WIDTH-1:0]           BAUD_VAL,
    input  logic [3:0]                      NUM_BITS,
    input  logic                            PARITY_EN,
    input  logic                            ODD_N_EVEN,
    input  logic                            STOP2,
    input  logic                            WR_EN,
    input  logic [DATA_WIDTH-1:0]           DATA_IN,
    input  logic                            RD_EN,
    output logic [DATA_WIDTH-1:0]           DATA_OUT,
    input  logic                            RX,
    output logic                            TX,
    output logic                            TX_FULL,
    output logic                            TX_EMPTY,
    output logic                            RX_FULL,
    output logic                            RX_EMPTY,
    output logic [$clog2(RX_DEPTH+1)-1:0]   RX_COUNT,
    output logic                            TX_BUSY,
    input  logic                            CLR_ERR,
    output logic                            PARITY_ERR,
    output logic                            FRAMING_ERR,
    output logic                            OVERFLOW,
    output logic                            BREAK_DET
);

    localparam int unsigned TXAW = $clog2(TX_DEPTH);
    localparam int unsigned TXCW = $clog2(TX_DEPTH + 1);
    localparam int unsigned RXAW = $clog2(RX_DEPTH);
    localparam int unsigned RXCW = $clog2(RX_DEPTH + 1);
    localparam int unsigned OSW  = $clog2(OVERSAMPLE);

    localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_S0   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] OS_S1   = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] OS_S2   = OSW'(OVERSAMPLE / 2 + 1);

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    logic [BAUD_WIDTH-1:0] baud_cnt_q;
    logic                  tick;

    assign tick = (baud_cnt_q == BAUD_VAL);

    // ">=" also recovers when BAUD_VAL shrinks below the running count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            baud_cnt_q <= '0;
        end else if (baud_cnt_q >= BAUD_VAL) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame configuration helpers
    // ------------------------------------------------------------------
    logic [3:0]            num_bits_clamped;
    logic [DATA_WIDTH-1:0] data_mask;

    always_comb begin
        num_bits_clamped = NUM_BITS;
        if (NUM_BITS < 4'd5) begin
            num_bits_clamped = 4'd5;
        end else if (NUM_BITS > 4'(DATA_WIDTH)) begin
            num_bits_clamped = 4'(DATA_WIDTH);
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            data_mask[i] = (4'(i) < num_bits_clamped);
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] tx_mem_q [TX_DEPTH];
    logic [TXAW-1:0]       tx_wr_ptr_q, tx_rd_ptr_q;
    logic [TXCW-1:0]       tx_cnt_q, tx_cnt_d;
    logic                  tx_push, tx_pop;
    logic [DATA_WIDTH-1:0] tx_head;

    assign TX_FULL  = (tx_cnt_q == TXCW'(TX_DEPTH));
    assign TX_EMPTY = (tx_cnt_q == '0);
    assign tx_push  = WR_EN && !TX_FULL;
    assign tx_head  = tx_mem_q[tx_rd_ptr_q];

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + TXCW'(1);
        end else if (!tx_push && tx_pop) begin
            tx_cnt_d = tx_cnt_q - TXCW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) begin
            tx_mem_q[tx_wr_ptr_q] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TXAW'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TXAW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    tx_state_e             tx_state_q, tx_state_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [3:0]            tx_nbits_q, tx_nbits_d;
    logic                  tx_par_en_q, tx_par_en_d;
    logic                  tx_par_bit_q, tx_par_bit_d;
    logic                  tx_stop2_q, tx_stop2_d;
    logic [OSW-1:0]        tx_tick_q, tx_tick_d;
    logic [3:0]            tx_bit_q, tx_bit_d;
    logic                  tx_bit_done, tx_load;

    assign tx_bit_done = tick && (tx_tick_q == OS_LAST);

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_shift_d   = tx_shift_q;
        tx_nbits_d   = tx_nbits_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_stop2_d   = tx_stop2_q;
        tx_tick_d    = tick ? tx_tick_q + OSW'(1) : tx_tick_q;
        tx_bit_d     = tx_bit_q;
        tx_load      = 1'b0;
        tx_pop       = 1'b0;

        unique case (tx_state_q)
            TxIdle: begin
                if (!TX_EMPTY) tx_load = 1'b1;
            end
            TxStart: begin
                if (tx_bit_done) begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                end
            end
            TxData: begin
                if (tx_bit_done) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == tx_nbits_q - 4'd1) begin
                        tx_state_d = tx_par_en_q ? TxParity : TxStop;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            TxParity: begin
                if (tx_bit_done) begin
                    tx_state_d = TxStop;
                    tx_bit_d   = '0;
                end
            end
            TxStop: begin
                if (tx_bit_done) begin
                    if (tx_stop2_q && (tx_bit_q == '0)) begin
                        tx_bit_d = 4'd1;
                    end else if (!TX_EMPTY) begin
                        // Chain the next frame straight from the stop bit.
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            default: tx_state_d = TxIdle;
        endcase

        if (tx_load) begin
            tx_pop       = 1'b1;
            tx_state_d   = TxStart;
            tx_tick_d    = '0;
            tx_bit_d     = '0;
            tx_shift_d   = tx_head & data_mask;
            tx_nbits_d   = num_bits_clamped;
            tx_par_en_d  = PARITY_EN;
            tx_par_bit_d = (^(tx_head & data_mask)) ^ ODD_N_EVEN;
            tx_stop2_d   = STOP2;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_state_q   <= TxIdle;
            tx_shift_q   <= '0;
            tx_nbits_q   <= 4'd8;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            tx_stop2_q   <= 1'b0;
            tx_tick_q    <= '0;
            tx_bit_q     <= '0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_shift_q   <= tx_shift_d;
            tx_nbits_q   <= tx_nbits_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_bit_q <= tx_par_bit_d;
            tx_stop2_q   <= tx_stop2_d;
            tx_tick_q    <= tx_tick_d;
            tx_bit_q     <= tx_bit_d;
        end
    end

    always_comb begin
        TX = 1'b1;
        unique case (tx_state_q)
            TxStart:  TX = 1'b0;
            TxData:   TX = tx_shift_q[0];
            TxParity: TX = tx_par_bit_q;
            default:  TX = 1'b1;
        endcase
    end

    assign TX_BUSY = (tx_state_q != TxIdle);

    // ------------------------------------------------------------------
    // RX synchroniser and FSM
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
    } rx_state_e;

    rx_state_e             rx_state_q, rx_state_d;
    logic [OSW-1:0]        rx_tick_q, rx_tick_d;
    logic [3:0]            rx_bit_q, rx_bit_d;
    logic [1:0]            rx_samp_q, rx_samp_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [3:0]            rx_nbits_q, rx_nbits_d;
    logic                  rx_par_en_q, rx_par_en_d;
    logic                  rx_odd_q, rx_odd_d;
    logic                  rx_par_acc_q, rx_par_acc_d;
    logic                  rx_par_bad_q, rx_par_bad_d;
    logic                  rx_any_one_q, rx_any_one_d;
    logic                  rx_wr_pend_q, rx_wr_pend_d;
    logic [DATA_WIDTH-1:0] rx_wr_data_q, rx_wr_data_d;
    logic                  rx_decide, rx_bit_done, rx_maj;
    logic                  set_par_err, set_frm_err, set_break, set_ovf;

    assign rx_decide   = tick && (rx_tick_q == OS_S2);
    assign rx_bit_done = tick && (rx_tick_q == OS_LAST);
    // Third sample is the live synced value at the decision tick.
    assign rx_maj = (rx_samp_q[0] & rx_samp_q[1]) | (rx_samp_q[0] & rx_sync_q) |
                    (rx_samp_q[1] & rx_sync_q);

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_tick_d    = tick ? rx_tick_q + OSW'(1) : rx_tick_q;
        rx_bit_d     = rx_bit_q;
        rx_samp_d    = rx_samp_q;
        rx_data_d    = rx_data_q;
        rx_nbits_d   = rx_nbits_q;
        rx_par_en_d  = rx_par_en_q;
        rx_odd_d     = rx_odd_q;
        rx_par_acc_d = rx_par_acc_q;
        rx_par_bad_d = rx_par_bad_q;
        rx_any_one_d = rx_any_one_q;
        rx_wr_pend_d = 1'b0;
        rx_wr_data_d = rx_wr_data_q;
        set_par_err  = 1'b0;
        set_frm_err  = 1'b0;
        set_break    = 1'b0;

        if (tick && (rx_tick_q == OS_S0)) rx_samp_d[0] = rx_sync_q;
        if (tick && (rx_tick_q == OS_S1)) rx_samp_d[1] = rx_sync_q;

        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    rx_state_d   = RxStart;
                    rx_tick_d    = '0;
                    rx_bit_d     = '0;
                    rx_data_d    = '0;
                    rx_par_acc_d = 1'b0;
                    rx_par_bad_d = 1'b0;
                    rx_any_one_d = 1'b0;
                    rx_nbits_d   = num_bits_clamped;
                    rx_par_en_d  = PARITY_EN;
                    rx_odd_d     = ODD_N_EVEN;
                end
            end
            RxStart: begin
                if (rx_decide && rx_maj) begin
                    rx_state_d = RxIdle;
                end else if (rx_bit_done) begin
                    rx_state_d = RxData;
                    rx_bit_d   = '0;
                end
            end
            RxData: begin
                if (rx_decide) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (rx_bit_q == 4'(i)) rx_data_d[i] = rx_maj;
                    end
                    rx_par_acc_d = rx_par_acc_q ^ rx_maj;
                    rx_any_one_d = rx_any_one_q | rx_maj;
                end
                if (rx_bit_done) begin
                    if (rx_bit_q == rx_nbits_q - 4'd1) begin
                        rx_state_d = rx_par_en_q ? RxParity : RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            RxParity: begin
                if (rx_decide) begin
                    rx_any_one_d = rx_any_one_q | rx_maj;
                    rx_par_bad_d = (rx_maj != (rx_par_acc_q ^ rx_odd_q));
                end
                if (rx_bit_done) rx_state_d = RxStop;
            end
            RxStop: begin
                // Only the first stop bit is checked; leave as soon as it is decided.
                if (rx_decide) begin
                    rx_state_d = RxWaitHigh;
                    if (!rx_maj) set_frm_err = 1'b1;
                    if (!rx_maj && !rx_any_one_q) begin
                        set_break = 1'b1;
                    end else begin
                        rx_wr_pend_d = 1'b1;
                        rx_wr_data_d = rx_data_q;
                        set_par_err  = rx_par_bad_q;
                    end
                end
            end
            RxWaitHigh: begin
                if (rx_sync_q) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_state_q   <= RxIdle;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_samp_q    <= 2'b11;
            rx_data_q    <= '0;
            rx_nbits_q   <= 4'd8;
            rx_par_en_q  <= 1'b0;
            rx_odd_q     <= 1'b0;
            rx_par_acc_q <= 1'b0;
            rx_par_bad_q <= 1'b0;
            rx_any_one_q <= 1'b0;
            rx_wr_pend_q <= 1'b0;
            rx_wr_data_q <= '0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_tick_q    <= rx_tick_d;
            rx_bit_q     <= rx_bit_d;
            rx_samp_q    <= rx_samp_d;
            rx_data_q    <= rx_data_d;
            rx_nbits_q   <= rx_nbits_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_odd_q     <= rx_odd_d;
            rx_par_acc_q <= rx_par_acc_d;
            rx_par_bad_q <= rx_par_bad_d;
            rx_any_one_q <= rx_any_one_d;
            rx_wr_pend_q <= rx_wr_pend_d;
            rx_wr_data_q <= rx_wr_data_d;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_mem_q [RX_DEPTH];
    logic [RXAW-1:0]       rx_wr_ptr_q, rx_rd_ptr_q;
    logic [RXCW-1:0]       rx_cnt_q, rx_cnt_d;
    logic                  rx_push, rx_pop;

    assign RX_FULL  = (rx_cnt_q == RXCW'(RX_DEPTH));
    assign RX_EMPTY = (rx_cnt_q == '0);
    assign RX_COUNT = rx_cnt_q;
    assign rx_push  = rx_wr_pend_q && !RX_FULL;
    assign set_ovf  = rx_wr_pend_q && RX_FULL;
    assign rx_pop   = RD_EN && !RX_EMPTY;
    assign DATA_OUT = RX_EMPTY ? '0 : rx_mem_q[rx_rd_ptr_q];

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + RXCW'(1);
        end else if (!rx_push && rx_pop) begin
            rx_cnt_d = rx_cnt_q - RXCW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) begin
            rx_mem_q[rx_wr_ptr_q] <= rx_wr_data_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
        end else begin
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RXAW'(1);
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RXAW'(1);
            rx_cnt_q <= rx_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags: a set wins over a simultaneous clear
    // ------------------------------------------------------------------
    logic parity_err_q, framing_err_q, overflow_q, break_det_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overflow_q    <= 1'b0;
            break_det_q   <= 1'b0;
        end else begin
            parity_err_q  <= set_par_err ? 1'b1 : (CLR_ERR ? 1'b0 : parity_err_q);
            framing_err_q <= set_frm_err ? 1'b1 : (CLR_ERR ? 1'b0 : framing_err_q);
            overflow_q    <= set_ovf     ? 1'b1 : (CLR_ERR ? 1'b0 : overflow_q);
            break_det_q   <= set_break   ? 1'b1 : (CLR_ERR ? 1'b0 : break_det_q);
        end
    end

    assign PARITY_ERR  = parity_err_q;
    assign FRAMING_ERR = framing_err_q;
    assign OVERFLOW    = overflow_q;
    assign BREAK_DET   = break_det_q;

endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
Parametrised next-generation UART core: programmable baud divider, selectable oversampling, 5..9 data bits, optional odd/even parity, 1 or 2 stop bits. Transmit and receive FIFOs have independent power-of-two depths. The receiver uses 3-sample majority voting and adds break detection. Sticky error flags are cleared by an explicit strobe. Sits between a host register interface (APB wrapper) and the RX/TX pins. Replaces the fixed 8-bit, fixed-FIFO core in new designs.

Parameters:
DATA_WIDTH, 8, maximum data bits per frame and FIFO word width (5..9)
TX_DEPTH, 16, TX FIFO depth, power of two, >=2
RX_DEPTH, 16, RX FIFO depth, power of two, >=2
OVERSAMPLE, 16, baud ticks per bit (8 or 16 only)
BAUD_WIDTH, 16, width of BAUD_VAL

Ports:
CLK  in  1  system clock; single clock domain
RESET  in  1  synchronous, active-high reset
BAUD_VAL  in  BAUD_WIDTH  divider; tick period = BAUD_VAL+1 clocks
NUM_BITS  in  4  data bits per frame, 5..DATA_WIDTH; values outside this range are clamped
PARITY_EN  in  1  1 = parity bit present
ODD_N_EVEN  in  1  1 = odd parity, 0 = even parity
STOP2  in  1  1 = TX sends two stop bits
WR_EN  in  1  push DATA_IN to TX FIFO
DATA_IN  in  DATA_WIDTH  TX data; bits above NUM_BITS are ignored
RD_EN  in  1  pop RX FIFO head
DATA_OUT  out  DATA_WIDTH  RX FIFO head (first-word fall-through), zero-extended
RX  in  1  serial input, asynchronous
TX  out  1  serial output
TX_FULL, TX_EMPTY, RX_FULL, RX_EMPTY  out  1 each  FIFO status
RX_COUNT  out  $clog2(RX_DEPTH+1)  RX FIFO occupancy
TX_BUSY  out  1  frame in progress on TX
CLR_ERR  in  1  clears all sticky error flags
PARITY_ERR, FRAMING_ERR, OVERFLOW, BREAK_DET  out  1 each  sticky error flags

Behaviour:
- Reset values: TX=1, TX_BUSY=0, both FIFOs empty (TX_EMPTY=1, RX_EMPTY=1, TX_FULL=0, RX_FULL=0, RX_COUNT=0), DATA_OUT=0, all error flags 0. Reset mid-frame returns both FSMs to IDLE; TX=1 after the same edge; the partial frame is lost.
- Baud generator: free-running counter 0..BAUD_VAL; one-clock tick when counter==BAUD_VAL. BAUD_VAL=0 gives a tick every clock. If BAUD_VAL changes mid-count and counter>BAUD_VAL, the counter wraps to 0 on the next clock.
- FIFOs: WR_EN while TX_FULL is ignored, with no overwrite. RD_EN while RX_EMPTY is ignored. A push and pop in the same cycle are both honoured and the count is unchanged. Pointers wrap modulo depth. Status flags update on the edge after the access.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO is non-empty, pop the head and latch the word plus NUM_BITS/PARITY_EN/ODD_N_EVEN/STOP2 into a frame register. TX_BUSY=1, go to START. TX=0 from the next clock.
  - Each bit lasts exactly OVERSAMPLE ticks, counted by a tick sub-counter cleared on entry to START.
  - DATA: shift out LSB first, NUM_BITS bits.
  - PARITY (only if PARITY_EN): XOR of the data bits, inverted for odd parity.
  - STOP: 1 or 2 bit periods of 1. At the end go to IDLE with TX_BUSY=0. Back-to-back frames are possible with no idle gap.
- RX synchroniser: 2-flop, reset to 1.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. Config is latched on start detect.
  - IDLE: synced RX=0 starts the sample counter and moves to START.
  - Every bit is decided by majority of the samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
  - START: majority=1 is a false start; return to IDLE with no flag.
  - PARITY: a mismatch sets PARITY_ERR; the word is still written.
  - STOP: only the first stop bit is checked. Majority=0 sets FRAMING_ERR; the word is still written, unless it is a break.
  - Break: data, parity (if enabled) and stop all 0. Sets BREAK_DET and FRAMING_ERR; no FIFO write.
  - FIFO write occurs one clock after the stop decision, so RX_EMPTY falls two clocks after the stop decision. If RX_FULL, set OVERFLOW and drop the word; existing contents are untouched.
  - After STOP go to WAIT_HIGH, which stays until synced RX=1 and then returns to IDLE. This prevents a break retriggering.
- Error flags: sticky. Set has priority over CLR_ERR in the same cycle.

Test Plan:
- BAUD_VAL=0, OVERSAMPLE=16, 8N1, write 0xA5 -> TX low 16 clocks, then bits 1,0,1,0,0,1,0,1 for 16 clocks each, then high 16 clocks; TX_BUSY high for exactly 160 clocks.
- TX looped to RX, NUM_BITS=7, PARITY_EN=1, ODD_N_EVEN=1, STOP2=1, BAUD_VAL=3, write 0x55, 0x2A -> RX_COUNT=2, DATA_OUT=0x55 then 0x2A after RD_EN, no error flags.
- Corrupt the parity bit of 0x3C (8E1) -> PARITY_ERR=1, 0x3C in FIFO; CLR_ERR pulse -> PARITY_ERR=0.
- RX_DEPTH=4: send 5 frames 0x01..0x05 without reads -> RX_FULL=1, RX_COUNT=4, OVERFLOW=1, reads return 0x01..0x04; a 5th RD_EN is ignored.
- RX low for 4 clocks (OVERSAMPLE=16, BAUD_VAL=0) -> false start, RX_EMPTY stays 1. RX low for 20 bit periods -> BREAK_DET=1 and FRAMING_ERR=1, no write; next valid 0x81 received correctly after RX returns high.
- RESET asserted mid-TX frame, then WR_EN 0x0F -> TX=1 after the reset edge, FIFOs empty, then a clean 0x0F frame.
